game_round_tracker: RTL and testbench
=====================================

# game_round_tracker

Downstream of the red/white compare stage: consumes one scored guess per round, counts turns, decides win/loss and keeps a readable per-turn history for display. Drives the `guess_enable` gate back to the control FSM so no further guesses load once a game ends. Sits between the datapath's `red_out`/`white_out`/`guess` outputs and the HEX/display logic.

## Interface
- `MAX_TURNS`, 8: turns per game, legal range 1..15.
- `PEG_W`, 3: bits per peg and per red/white count.
- `CODE_LEN`, 4: pegs per code.
- `clock`  in  1  rising-edge clock (CLOCK_50 domain).
- `resetn`  in  1  asynchronous, active-low reset.
- `new_game`  in  1  single-cycle pulse; clears game state.
- `result_valid`  in  1  single-cycle pulse; `red`, `white`, `guess` valid this cycle.
- `red`  in  PEG_W  exact-position matches.
- `white`  in  PEG_W  colour-only matches.
- `guess`  in  PEG_W*CODE_LEN  guess that was scored.
- `rd_idx`  in  4  history read index (0 = first turn).
- `rd_guess`  out  PEG_W*CODE_LEN  stored guess at `rd_idx`.
- `rd_red`, `rd_white`  out  PEG_W each  stored scores at `rd_idx`.
- `rd_valid`  out  1  `rd_idx` < `turn_count`.
- `turn_count`  out  4  turns recorded this game.
- `playing`, `won`, `lost`  out  1 each  one-hot game status.
- `guess_enable`  out  1  equals `playing`; control FSM loads guesses only when high.
- `score_err`  out  1  sticky: an illegal score was received this game.

## Operation
- States: PLAYING, WON, LOST. Reset and `new_game` enter PLAYING.
- PLAYING, `result_valid`: write {guess, red, white} to history[turn_count]; turn_count += 1. Then: red == CODE_LEN -> WON; else turn_count+1 == MAX_TURNS -> LOST; else stay PLAYING.
- Win checked before loss: winning on turn MAX_TURNS gives WON.
- WON/LOST: `result_valid` ignored (no write, no count, no state change). Only `new_game` leaves.
- `new_game` and `result_valid` in the same cycle: `new_game` wins; the result is dropped.
- `new_game` clears turn_count, score_err, state; history contents need not be cleared (masked by `rd_valid`).
- Illegal score: red > CODE_LEN, white > CODE_LEN, or red+white > CODE_LEN (sum computed PEG_W+1 bits wide, no wrap). Entry is still recorded and the turn counted; score_err set sticky; red > CODE_LEN never produces WON.
- Read port: `rd_guess/rd_red/rd_white` combinational from history[rd_idx]; `rd_idx` ≥ MAX_TURNS returns zeros with `rd_valid` = 0.

## Timing
- Reset values: turn_count 0, playing 1, won 0, lost 0, guess_enable 1, score_err 0, rd_valid 0, read data 0 for unwritten entries after reset (history reset to 0 on `resetn` only).
- Latency: `result_valid` sampled at edge N; turn_count, status, score_err and history update visible after edge N; `guess_enable` falls in that same cycle when the game ends.
- Read port 0-cycle latency; a write at edge N is readable right after edge N.
- Back-to-back `result_valid` on consecutive cycles accepted (upstream produces at most one per round; no backpressure).
- `resetn` asserted mid-game: all registers clear immediately, independent of clock.

## Structure
- Shared package `mastermind_pkg`: PEG_W, CODE_LEN, MAX_TURNS defaults, game-state encoding (PLAYING/WON/LOST), history entry width (PEG_W*CODE_LEN + 2*PEG_W).
- One sub-module `turn_history`: MAX_TURNS-entry register file, one write port, one combinational read port, async reset.
- FSM, turn counter and score checking stay in the top.

## Test plan
- Reset, then result red=4 white=0 guess=12'o1234 -> won=1, turn_count=1, guess_enable=0, rd_idx=0 returns 12'o1234/4/0.
- Eight results red=1 white=2 -> lost=1 after 8th, turn_count=8; 9th `result_valid` ignored, turn_count stays 8.
- MAX_TURNS=8, seven misses then red=4 on turn 8 -> won=1, lost=0.
- result red=3 white=2 -> score_err=1, turn_count=1, still playing; `new_game` -> score_err=0, turn_count=0.
- `new_game` and `result_valid` (red=4) in same cycle -> playing=1, turn_count=0, won=0.
- `resetn` low for one cycle after 3 turns -> all outputs at reset values without a clock edge; rd_idx=0 gives rd_valid=0.

Source files
------------

// File: rtl/mastermind_pkg.sv
// Shared constants and game-state encoding for the mastermind round tracker.
package mastermind_pkg;

    localparam int unsigned DEF_PEG_W     = 3;
    localparam int unsigned DEF_CODE_LEN  = 4;
    localparam int unsigned DEF_MAX_TURNS = 8;
    localparam int unsigned IDX_W         = 4;
    localparam int unsigned DEF_ENTRY_W   = DEF_PEG_W * DEF_CODE_LEN + 2 * DEF_PEG_W;

    typedef enum logic [1:0] {
        ST_PLAYING = 2'd0,
        ST_WON     = 2'd1,
        ST_LOST    = 2'd2
    } game_state_e;

endpackage

// File: rtl/turn_history.sv
// Per-turn history register file: one write port, one combinational read port.
module turn_history
    import mastermind_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_MAX_TURNS,
    parameter int unsigned ENTRY_W = DEF_ENTRY_W
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                mem_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Out-of-range indices fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/game_round_tracker.sv
// Game status FSM, turn counter and score checking over a per-turn history.
module game_round_tracker
    import mastermind_pkg::*;
#(
    parameter int unsigned MAX_TURNS = DEF_MAX_TURNS,
    parameter int unsigned PEG_W     = DEF_PEG_W,
    parameter int unsigned CODE_LEN  = DEF_CODE_LEN
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      new_game,
    input  logic                      result_valid,
    input  logic [PEG_W-1:0]          red,
    input  logic [PEG_W-1:0]          white,
    input  logic [PEG_W*CODE_LEN-1:0] guess,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic [PEG_W*CODE_LEN-1:0] rd_guess,
    output logic [PEG_W-1:0]          rd_red,
    output logic [PEG_W-1:0]          rd_white,
    output logic                      rd_valid,
    output logic [IDX_W-1:0]          turn_count,
    output logic                      playing,
    output logic                      won,
    output logic                      lost,
    output logic                      guess_enable,
    output logic                      score_err
);

    localparam int unsigned GUESS_W = PEG_W * CODE_LEN;
    localparam int unsigned ENTRY_W = GUESS_W + 2 * PEG_W;
    localparam int unsigned SUM_W   = PEG_W + 1;

    game_state_e        state_q, state_d;
    logic [IDX_W-1:0]   turn_cnt_q, turn_cnt_d;
    logic               score_err_q, score_err_d;
    logic               wr_en;
    logic [SUM_W-1:0]   red_ext, white_ext, score_sum;
    logic               score_bad;
    logic [ENTRY_W-1:0] rd_data;

    // Sum is one bit wider than a count so it never wraps.
    always_comb begin
        red_ext   = SUM_W'(red);
        white_ext = SUM_W'(white);
        score_sum = red_ext + white_ext;
        score_bad = (red_ext > SUM_W'(CODE_LEN)) || (white_ext > SUM_W'(CODE_LEN))
                  || (score_sum > SUM_W'(CODE_LEN));
    end

    always_comb begin
        state_d     = state_q;
        turn_cnt_d  = turn_cnt_q;
        score_err_d = score_err_q;
        wr_en       = 1'b0;
        if (new_game) begin
            state_d     = ST_PLAYING;
            turn_cnt_d  = '0;
            score_err_d = 1'b0;
        end else if (result_valid && (state_q == ST_PLAYING)) begin
            wr_en      = 1'b1;
            turn_cnt_d = turn_cnt_q + IDX_W'(1);
            if (score_bad) begin
                score_err_d = 1'b1;
            end
            // Win takes priority over running out of turns.
            if (red_ext == SUM_W'(CODE_LEN)) begin
                state_d = ST_WON;
            end else if (turn_cnt_d == IDX_W'(MAX_TURNS)) begin
                state_d = ST_LOST;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_PLAYING;
            turn_cnt_q  <= '0;
            score_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            turn_cnt_q  <= turn_cnt_d;
            score_err_q <= score_err_d;
        end
    end

    turn_history #(
        .DEPTH   (MAX_TURNS),
        .ENTRY_W (ENTRY_W)
    ) u_turn_history (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_idx  (turn_cnt_q),
        .wr_data ({guess, red, white}),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign rd_guess     = rd_data[ENTRY_W-1 -: GUESS_W];
    assign rd_red       = rd_data[2*PEG_W-1 -: PEG_W];
    assign rd_white     = rd_data[PEG_W-1:0];
    assign rd_valid     = (rd_idx < turn_cnt_q);
    assign turn_count   = turn_cnt_q;
    assign playing      = (state_q == ST_PLAYING);
    assign won          = (state_q == ST_WON);
    assign lost         = (state_q == ST_LOST);
    assign guess_enable = playing;
    assign score_err    = score_err_q;

endmodule

// File: tb/tb_game_round_tracker.sv
// Randomized and directed checking of game_round_tracker against a behavioural game model.
module tb_game_round_tracker;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        new_game = 1'b0;
    logic        result_valid = 1'b0;
    logic [2:0]  red = '0;
    logic [2:0]  white = '0;
    logic [11:0] guess = '0;
    logic [3:0]  rd_idx = '0;
    logic [11:0] rd_guess;
    logic [2:0]  rd_red, rd_white;
    logic        rd_valid;
    logic [3:0]  turn_count;
    logic        playing, won, lost, guess_enable, score_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: status 0=in play, 1=won, 2=lost.
    int m_status, m_turns;
    bit m_err;
    int h_guess [8];
    int h_red   [8];
    int h_white [8];

    game_round_tracker dut (
        .clock(clock), .resetn(resetn), .new_game(new_game), .result_valid(result_valid),
        .red(red), .white(white), .guess(guess), .rd_idx(rd_idx),
        .rd_guess(rd_guess), .rd_red(rd_red), .rd_white(rd_white), .rd_valid(rd_valid),
        .turn_count(turn_count), .playing(playing), .won(won), .lost(lost),
        .guess_enable(guess_enable), .score_err(score_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_status = 0;
        m_turns  = 0;
        m_err    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            h_guess[i] = 0; h_red[i] = 0; h_white[i] = 0;
        end
    endtask

    task automatic model_edge(input bit ng, input bit rv, input int r, input int w, input int g);
        if (ng) begin
            m_status = 0; m_turns = 0; m_err = 1'b0;
        end else if (rv && m_status == 0) begin
            h_guess[m_turns] = g; h_red[m_turns] = r; h_white[m_turns] = w;
            m_turns++;
            if (r > 4 || w > 4 || r + w > 4) m_err = 1'b1;
            if (r == 4) m_status = 1;
            else if (m_turns == 8) m_status = 2;
        end
    endtask

    task automatic check_read(input int idx);
        rd_idx = 4'(idx);
        #1;
        check_eq("rd_valid", 32'(rd_valid), 32'(idx < m_turns));
        check_eq("rd_guess", 32'(rd_guess), (idx < 8) ? 32'(h_guess[idx]) : 32'd0);
        check_eq("rd_red",   32'(rd_red),   (idx < 8) ? 32'(h_red[idx])   : 32'd0);
        check_eq("rd_white", 32'(rd_white), (idx < 8) ? 32'(h_white[idx]) : 32'd0);
    endtask

    task automatic check_all();
        check_eq("turn_count",   32'(turn_count),   32'(m_turns));
        check_eq("playing",      32'(playing),      32'(m_status == 0));
        check_eq("won",          32'(won),          32'(m_status == 1));
        check_eq("lost",         32'(lost),         32'(m_status == 2));
        check_eq("guess_enable", 32'(guess_enable), 32'(m_status == 0));
        check_eq("score_err",    32'(score_err),    32'(m_err));
        check_read(int'($urandom_range(0, 15)));
    endtask

    task automatic step(input bit ng, input bit rv, input int r, input int w, input int g);
        @(negedge clock);
        new_game     = ng;
        result_valid = rv;
        red          = 3'(r);
        white        = 3'(w);
        guess        = 12'(g);
        @(posedge clock);
        model_edge(ng, rv, r, w, g);
        #1;
        new_game     = 1'b0;
        result_valid = 1'b0;
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clock);
        resetn = 1'b1;

        // Immediate win on the first turn.
        step(0, 1, 4, 0, 'o1234);
        check_eq("t1_won", 32'(won), 32'd1);
        check_eq("t1_ge", 32'(guess_enable), 32'd0);
        check_read(0);
        check_eq("t1_rd_guess", 32'(rd_guess), 32'o1234);

        // Eight misses lose; a ninth result is ignored.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 2, int'($urandom_range(0, 4095)));
        check_eq("t2_lost", 32'(lost), 32'd1);
        check_eq("t2_turns", 32'(turn_count), 32'd8);
        step(0, 1, 4, 0, 'o7777);
        check_eq("t2_ignored", 32'(turn_count), 32'd8);

        // Win on the last allowed turn beats the loss.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 0, int'($urandom_range(0, 4095)));
        step(0, 1, 4, 0, 'o4321);
        check_eq("t3_won", 32'(won), 32'd1);
        check_eq("t3_lost", 32'(lost), 32'd0);

        // Illegal score is recorded and sticky until new_game.
        step(1, 0, 0, 0, 0);
        step(0, 1, 3, 2, 'o1111);
        check_eq("t4_err", 32'(score_err), 32'd1);
        check_eq("t4_play", 32'(playing), 32'd1);
        step(1, 0, 0, 0, 0);
        check_eq("t4_err_clr", 32'(score_err), 32'd0);

        // red above CODE_LEN never wins.
        step(0, 1, 7, 0, 'o2222);
        check_eq("t4b_nowin", 32'(won), 32'd0);

        // new_game beats a simultaneous result.
        step(1, 1, 4, 0, 'o3333);
        check_eq("t5_turns", 32'(turn_count), 32'd0);
        check_eq("t5_won", 32'(won), 32'd0);

        // Asynchronous reset mid-game.
        for (int i = 0; i < 3; i++) step(0, 1, 2, 1, int'($urandom_range(0, 4095)));
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        check_read(0);
        @(negedge clock);
        resetn = 1'b1;

        // Random play.
        for (int n = 0; n < 600; n++) begin
            bit ng, rv;
            int r, w;
            ng = ($urandom_range(0, 19) == 0);
            rv = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) begin
                r = int'($urandom_range(0, 7)); w = int'($urandom_range(0, 7));
            end else begin
                r = int'($urandom_range(0, 4)); w = int'($urandom_range(0, 4 - r));
                if (r == 4 && $urandom_range(0, 2) != 0) r = 3;
            end
            step(ng, rv, r, w, int'($urandom_range(0, 4095)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
